// File: rtl/dcache_pkg.sv
// dcache_pkg: FSM encoding, default cache geometry and address field helpers
package dcache_pkg;
  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_LINES = 64;
  localparam int DEF_WORDS_PER_LINE = 4;
  localparam int OFFSET_BITS = 2 + $clog2(DEF_WORDS_PER_LINE);
  localparam int INDEX_BITS = $clog2(DEF_LINES);
  localparam int TAG_BITS = DEF_WIDTH - OFFSET_BITS - INDEX_BITS;
  // bits [lo +: bits] of an address, zero-extended
  function automatic logic [63:0] field(input logic [63:0] a, input int lo, input int bits);
    return (a >> lo) & ~(64'hFFFF_FFFF_FFFF_FFFF << bits);
  endfunction
endpackage

// File: rtl/dcache_data_array.sv
// dcache_data_array: line x word storage with one write port and a combinational read port
module dcache_data_array #(
  parameter int width = 32,
  parameter int LINES = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                          clk,
  input  logic                          i_we,
  input  logic [$clog2(LINES)-1:0]      i_widx,
  input  logic [$clog2(WORDS_PER_LINE)-1:0] i_wword,
  input  logic [width-1:0]              i_wdata,
  input  logic [$clog2(LINES)-1:0]      i_ridx,
  input  logic [$clog2(WORDS_PER_LINE)-1:0] i_rword,
  output logic [width-1:0]              o_rdata
);
  logic [width-1:0] r_mem [LINES][WORDS_PER_LINE];
  // single write port, not reset
  always_ff @(posedge clk)
    if (i_we) r_mem[i_widx][i_wword] <= i_wdata;
  assign o_rdata = r_mem[i_ridx][i_rword];
endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped write-through no-allocate data cache with word-wide memory handshake
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int width = DEF_WIDTH,
  parameter int LINES = DEF_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [width-1:0] cpu_addr,
  input  logic [width-1:0] cpu_wdata,
  output logic [width-1:0] cpu_rdata,
  output logic             cpu_stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [width-1:0] mem_addr,
  output logic [width-1:0] mem_wdata,
  input  logic [width-1:0] mem_rdata,
  input  logic             mem_ready
);
  localparam int WB = $clog2(WORDS_PER_LINE);
  localparam int OB = 2 + WB;
  localparam int IB = $clog2(LINES);
  localparam int TB = width - OB - IB;
  state_t r_state, w_next;
  logic [WB-1:0] r_cnt;
  logic [LINES-1:0] r_valid;
  logic [TB-1:0] r_tag [LINES];
  logic [width-1:0] r_base;
  logic [IB-1:0] w_index, w_base_index, w_widx;
  logic [TB-1:0] w_tag, w_base_tag;
  logic [WB-1:0] w_word, w_wword;
  logic [width-1:0] w_rd, w_wdata;
  logic w_hit, w_beat, w_last, w_we;
  assign w_index = IB'(field(64'(cpu_addr), OB, IB));
  assign w_tag = TB'(field(64'(cpu_addr), OB + IB, TB));
  assign w_word = WB'(field(64'(cpu_addr), 2, WB));
  assign w_base_index = IB'(field(64'(r_base), OB, IB));
  assign w_base_tag = TB'(field(64'(r_base), OB + IB, TB));
  assign w_hit = r_valid[w_index] && r_tag[w_index] == w_tag;
  assign w_beat = r_state == REFILL && mem_ready;
  assign w_last = w_beat && r_cnt == WB'(WORDS_PER_LINE - 1);
  assign w_we = w_beat || (r_state == WRITE && mem_ready && w_hit);
  assign w_widx = w_beat ? w_base_index : w_index;
  assign w_wword = w_beat ? r_cnt : w_word;
  assign w_wdata = w_beat ? mem_rdata : cpu_wdata;
  dcache_data_array #(.width(width), .LINES(LINES), .WORDS_PER_LINE(WORDS_PER_LINE)) u_data (
    .clk(clk), .i_we(w_we), .i_widx(w_widx), .i_wword(w_wword), .i_wdata(w_wdata),
    .i_ridx(w_index), .i_rword(w_word), .o_rdata(w_rd)
  );
  // next state and all handshake outputs; everything reads 0 unless the state drives it
  always_comb begin
    w_next = r_state;
    cpu_stall = 1'b0;
    cpu_rdata = '0;
    mem_req = 1'b0;
    mem_we = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    case (r_state)
      IDLE: begin
        cpu_stall = cpu_req && (cpu_we || !w_hit);
        cpu_rdata = (cpu_req && !cpu_we && w_hit) ? w_rd : '0;
        w_next = !cpu_req ? IDLE : cpu_we ? WRITE : w_hit ? IDLE : REFILL;
      end
      REFILL: begin
        mem_req = 1'b1;
        mem_addr = r_base | width'({r_cnt, 2'b00});
        cpu_stall = 1'b1;
        w_next = w_last ? IDLE : REFILL;
      end
      WRITE: begin
        mem_req = 1'b1;
        mem_we = 1'b1;
        mem_addr = {cpu_addr[width-1:2], 2'b00};
        mem_wdata = cpu_wdata;
        cpu_stall = !mem_ready;
        w_next = mem_ready ? IDLE : WRITE;
      end
      default: w_next = IDLE;
    endcase
  end
  // state, refill base and beat counter; a line is invalid from refill start until its last beat lands
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_valid <= '0;
      r_base <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next == REFILL) begin
        r_base <= {cpu_addr[width-1:OB], OB'(0)};
        r_cnt <= '0;
        r_valid[w_index] <= 1'b0;
      end
      if (w_beat) r_cnt <= r_cnt + 1'b1;
      if (w_last) r_valid[w_base_index] <= 1'b1;
    end
  // tag captured with the last refill beat, not reset
  always_ff @(posedge clk)
    if (w_last) r_tag[w_base_index] <= w_base_tag;
endmodule
